horner_eval: RTL and testbench

HORNER_EVAL -- requirements
Module: horner_eval

---
 rtl/horner_pkg.sv | 15 +
 rtl/horner_eval_fxp_mac.sv | 56 +++++
 rtl/horner_eval.sv | 119 +++++++++++
 tb/tb_horner_eval.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/horner_pkg.sv
// Shared types and default widths for the Horner polynomial evaluator.
package horner_pkg;

   localparam int DATA_W_DEF     = 32;
   localparam int FRAC_W_DEF     = 16;
   localparam int ADDR_LINES_DEF = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      REWIND = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/horner_eval_fxp_mac.sv
// Combinational fixed-point step y = (acc*x >>> FRAC_W) + c.
// HORNER_SAT_EN selects saturating arithmetic with an overflow flag; otherwise the result wraps.
module fxp_mac
   import horner_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] x_i,
   input  logic [DATA_W-1:0] c_i,
   output logic [DATA_W-1:0] y_o,
   output logic              ovf_o
);

   // Both operands are sign-extended so the full-width product is exact.
   logic signed [2*DATA_W-1:0] prod;
   assign prod = $signed({{DATA_W{acc_i[DATA_W-1]}}, acc_i}) *
                 $signed({{DATA_W{x_i[DATA_W-1]}}, x_i});

`ifdef HORNER_SAT_EN
   localparam logic signed [2*DATA_W-1:0] PMAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W-1:0] PMIN = ~PMAX;

   logic signed [2*DATA_W-1:0] sh;
   logic        [DATA_W-1:0]   sh_sat;
   logic                       sh_ovf;
   logic signed [DATA_W:0]     sum;
   logic                       sum_ovf;

   always_comb begin
      sh     = prod >>> FRAC_W;
      sh_ovf = 1'b0;
      sh_sat = sh[DATA_W-1:0];
      if (sh > PMAX) begin
         sh_sat = PMAX[DATA_W-1:0];
         sh_ovf = 1'b1;
      end else if (sh < PMIN) begin
         sh_sat = PMIN[DATA_W-1:0];
         sh_ovf = 1'b1;
      end
      sum     = $signed({sh_sat[DATA_W-1], sh_sat}) + $signed({c_i[DATA_W-1], c_i});
      sum_ovf = sum[DATA_W] ^ sum[DATA_W-1];
      y_o     = sum[DATA_W-1:0];
      if (sum_ovf)
         y_o = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      ovf_o = sh_ovf | sum_ovf;
   end
`else
   logic [DATA_W-1:0] sh_lo;
   assign sh_lo = DATA_W'(prod >>> FRAC_W);
   assign y_o   = sh_lo + c_i;
   assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/horner_eval.sv
// Horner polynomial evaluator streaming coefficients (highest degree first) from an external FIFO.
// Optional HORNER_SAT_EN: saturating arithmetic with sticky ovf_o (wraps and ties ovf_o low otherwise).
module horner_eval
   import horner_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FRAC_W     = FRAC_W_DEF,
   parameter int ADDR_LINES = ADDR_LINES_DEF
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [DATA_W-1:0]     x_i,
   input  logic                  x_valid_i,
   output logic                  x_ready_o,
   input  logic [ADDR_LINES:0]   terms_i,
   input  logic [DATA_W-1:0]     coeff_data_i,
   input  logic                  coeff_empty_i,
   output logic                  coeff_rd_en_o,
   output logic                  coeff_redo_o,
   output logic [DATA_W-1:0]     y_o,
   output logic                  y_valid_o,
   input  logic                  y_ready_i,
   output logic                  ovf_o
);

   localparam logic [ADDR_LINES:0] MAX_TERMS = {1'b1, {ADDR_LINES{1'b0}}};
   localparam logic [ADDR_LINES:0] ONE       = {{ADDR_LINES{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     x_q, x_d;
   logic [DATA_W-1:0]     acc_q, acc_d;
   logic [ADDR_LINES:0]   terms_q, terms_d;
   logic [ADDR_LINES:0]   issued_q, issued_d;
   logic [ADDR_LINES:0]   consumed_q, consumed_d;
   logic                  dv_q;
   logic                  ovf_q, ovf_d;
   logic [DATA_W-1:0]     mac_y;
   logic                  mac_ovf;

   fxp_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_mac (
      .acc_i  (acc_q),
      .x_i    (x_q),
      .c_i    (coeff_data_i),
      .y_o    (mac_y),
      .ovf_o  (mac_ovf)
   );

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      acc_d         = acc_q;
      terms_d       = terms_q;
      issued_d      = issued_q;
      consumed_d    = consumed_q;
      ovf_d         = ovf_q;
      coeff_rd_en_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (x_valid_i) begin
               x_d        = x_i;
               terms_d    = (terms_i > MAX_TERMS) ? MAX_TERMS : terms_i;
               acc_d      = '0;
               issued_d   = '0;
               consumed_d = '0;
               ovf_d      = 1'b0;
               state_d    = (terms_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            coeff_rd_en_o = (issued_q < terms_q) && !coeff_empty_i;
            if (coeff_rd_en_o)
               issued_d = issued_q + ONE;
            // dv_q marks the cycle the FIFO presents the word strobed last cycle.
            if (dv_q) begin
               acc_d      = mac_y;
               ovf_d      = ovf_q | mac_ovf;
               consumed_d = consumed_q + ONE;
               if ((consumed_q + ONE) == terms_q)
                  state_d = REWIND;
            end
         end
         REWIND:  state_d = DONE;
         DONE:    if (y_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         x_q        <= '0;
         acc_q      <= '0;
         terms_q    <= '0;
         issued_q   <= '0;
         consumed_q <= '0;
         dv_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         terms_q    <= terms_d;
         issued_q   <= issued_d;
         consumed_q <= consumed_d;
         dv_q       <= coeff_rd_en_o;
         ovf_q      <= ovf_d;
      end
   end

   assign x_ready_o    = (state_q == IDLE);
   assign coeff_redo_o = (state_q == REWIND);
   assign y_valid_o    = (state_q == DONE);
   assign y_o          = acc_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_horner_eval.sv
// Directed bench for horner_eval with a behavioural coefficient FIFO (registered read, rewind on redo).
module tb_horner_eval;

   localparam int DW = 32;
   localparam int FW = 16;
   localparam int AL = 5;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] x_i;
   logic          x_valid_i;
   logic          x_ready_o;
   logic [AL:0]   terms_i;
   logic [DW-1:0] coeff_data_i;
   logic          coeff_empty_i;
   logic          coeff_rd_en_o;
   logic          coeff_redo_o;
   logic [DW-1:0] y_o;
   logic          y_valid_o;
   logic          y_ready_i;
   logic          ovf_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   horner_eval #(.DATA_W(DW), .FRAC_W(FW), .ADDR_LINES(AL)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .x_i           (x_i),
      .x_valid_i     (x_valid_i),
      .x_ready_o     (x_ready_o),
      .terms_i       (terms_i),
      .coeff_data_i  (coeff_data_i),
      .coeff_empty_i (coeff_empty_i),
      .coeff_rd_en_o (coeff_rd_en_o),
      .coeff_redo_o  (coeff_redo_o),
      .y_o           (y_o),
      .y_valid_o     (y_valid_o),
      .y_ready_i     (y_ready_i),
      .ovf_o         (ovf_o)
   );

   always #5 clk = ~clk;

   // FIFO model: strobes are sampled mid-cycle, data appears one edge after the strobe.
   logic [DW-1:0] mem [0:31];
   int            ptr;
   logic          rd_seen = 1'b0;
   logic          redo_seen = 1'b0;
   int            rd_cnt = 0;
   int            redo_cnt = 0;

   always @(negedge clk) begin
      rd_seen   = rstn & coeff_rd_en_o;
      redo_seen = rstn & coeff_redo_o;
      if (rd_seen) rd_cnt++;
      if (redo_seen) redo_cnt++;
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr          <= 0;
         coeff_data_i <= '0;
      end else if (redo_seen) begin
         ptr <= 0;
      end else if (rd_seen) begin
         coeff_data_i <= mem[ptr];
         ptr          <= ptr + 1;
      end
   end

   // Presents x/terms, waits for y_valid_o; lat = edges after the accepting edge (-1 on timeout).
   task automatic run_eval(input logic [DW-1:0] x, input logic [AL:0] t, input int stall_from,
                           input bit hold_valid, output logic [DW-1:0] y, output logic ovf,
                           output int lat);
      rd_cnt    = 0;
      redo_cnt  = 0;
      x_i       = x;
      terms_i   = t;
      x_valid_i = 1'b1;
      @(posedge clk); #1;
      if (hold_valid) begin
         x_i     = 32'h1234_5678;
         terms_i = 6'd1;
      end else begin
         x_valid_i = 1'b0;
      end
      lat = -1;
      for (int c = 0; c < 200; c++) begin
         coeff_empty_i = (stall_from >= 0) && (c >= stall_from) && (c < stall_from + 3);
         @(negedge clk);
         if (y_valid_o) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      coeff_empty_i = 1'b0;
      x_valid_i     = 1'b0;
      y   = y_o;
      ovf = ovf_o;
   endtask

   task automatic finish_eval();
      @(posedge clk); #1;
      y_ready_i = 1'b1;
      @(posedge clk); #1;
      y_ready_i = 1'b0;
   endtask

   task automatic load_basic();
      mem[0] = 32'h0001_0000;
      mem[1] = 32'h0000_0000;
      mem[2] = 32'hFFFF_0000;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (y_o !== '0) $display("FAIL reset_y got %h want 0", y_o); else pass_cnt++;
      total_cnt++; if (y_valid_o !== 1'b0) $display("FAIL reset_yvalid got %b want 0", y_valid_o); else pass_cnt++;
      total_cnt++; if (ovf_o !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf_o); else pass_cnt++;
      total_cnt++; if (coeff_rd_en_o !== 1'b0) $display("FAIL reset_rden got %b want 0", coeff_rd_en_o); else pass_cnt++;
      total_cnt++; if (coeff_redo_o !== 1'b0) $display("FAIL reset_redo got %b want 0", coeff_redo_o); else pass_cnt++;
      rstn = 1'b1;
      @(negedge clk);
      total_cnt++; if (x_ready_o !== 1'b1) $display("FAIL reset_xready got %b want 1", x_ready_o); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   // 2.0 in, 1 - 0 + ... : ((1)*2 + 0)*2 - 1 = 3.0
   task automatic test_basic();
      logic [DW-1:0] y; logic ovf; int lat;
      load_basic();
      run_eval(32'h0002_0000, 6'd3, -1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== 32'h0003_0000) $display("FAIL basic_y got %h want 00030000", y); else pass_cnt++;
      total_cnt++; if (lat !== 5) $display("FAIL basic_latency got %0d want 5", lat); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 3) $display("FAIL basic_rdcnt got %0d want 3", rd_cnt); else pass_cnt++;
      total_cnt++; if (redo_cnt !== 1) $display("FAIL basic_redo got %0d want 1", redo_cnt); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else pass_cnt++;
      finish_eval();
      total_cnt++; if (x_ready_o !== 1'b1) $display("FAIL basic_idle got %b want 1", x_ready_o); else pass_cnt++;
   endtask

   // Zero terms reaches DONE on the accepting edge itself.
   task automatic test_zero_terms();
      logic [DW-1:0] y; logic ovf; int lat;
      run_eval(32'h0005_0000, 6'd0, -1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== '0) $display("FAIL zero_y got %h want 0", y); else pass_cnt++;
      total_cnt++; if (lat !== 0) $display("FAIL zero_latency got %0d want 0", lat); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 0) $display("FAIL zero_rdcnt got %0d want 0", rd_cnt); else pass_cnt++;
      total_cnt++; if (redo_cnt !== 0) $display("FAIL zero_redo got %0d want 0", redo_cnt); else pass_cnt++;
      finish_eval();
   endtask

   task automatic test_empty_stall();
      logic [DW-1:0] y; logic ovf; int lat;
      load_basic();
      run_eval(32'h0002_0000, 6'd3, 1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== 32'h0003_0000) $display("FAIL stall_y got %h want 00030000", y); else pass_cnt++;
      total_cnt++; if (lat !== 8) $display("FAIL stall_latency got %0d want 8", lat); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 3) $display("FAIL stall_rdcnt got %0d want 3", rd_cnt); else pass_cnt++;
      total_cnt++; if (redo_cnt !== 1) $display("FAIL stall_redo got %0d want 1", redo_cnt); else pass_cnt++;
      finish_eval();
   endtask

   task automatic test_hold_ready();
      logic [DW-1:0] y; logic ovf; int lat;
      load_basic();
      run_eval(32'h0002_0000, 6'd3, -1, 1'b0, y, ovf, lat);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         total_cnt++; if (y_o !== 32'h0003_0000) $display("FAIL hold_y[%0d] got %h want 00030000", i, y_o); else pass_cnt++;
         total_cnt++; if (y_valid_o !== 1'b1) $display("FAIL hold_yvalid[%0d] got %b want 1", i, y_valid_o); else pass_cnt++;
         total_cnt++; if (x_ready_o !== 1'b0) $display("FAIL hold_xready[%0d] got %b want 0", i, x_ready_o); else pass_cnt++;
      end
      finish_eval();
      total_cnt++; if (y_valid_o !== 1'b0) $display("FAIL hold_release_yvalid got %b want 0", y_valid_o); else pass_cnt++;
      total_cnt++; if (x_ready_o !== 1'b1) $display("FAIL hold_release_xready got %b want 1", x_ready_o); else pass_cnt++;
   endtask

   // 2.0 * 32767.0 = 65534.0 does not fit Q16.16.
   task automatic test_overflow();
      logic [DW-1:0] y; logic ovf; int lat;
      mem[0] = 32'h0002_0000;
      mem[1] = 32'h0000_0000;
      run_eval(32'h7FFF_0000, 6'd2, -1, 1'b0, y, ovf, lat);
`ifdef HORNER_SAT_EN
      total_cnt++; if (y !== 32'h7FFF_FFFF) $display("FAIL ovf_y got %h want 7fffffff", y); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else pass_cnt++;
`else
      total_cnt++; if (y !== 32'hFFFE_0000) $display("FAIL ovf_y got %h want fffe0000", y); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_flag got %b want 0", ovf); else pass_cnt++;
`endif
      finish_eval();
   endtask

   // -1 LSB * 0.5 must floor to -1 LSB, not truncate to 0; ovf must clear on a new accept.
   task automatic test_floor();
      logic [DW-1:0] y; logic ovf; int lat;
      mem[0] = 32'hFFFF_FFFF;
      mem[1] = 32'h0000_0000;
      run_eval(32'h0000_8000, 6'd2, -1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== 32'hFFFF_FFFF) $display("FAIL floor_y got %h want ffffffff", y); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL floor_ovf got %b want 0", ovf); else pass_cnt++;
      finish_eval();
   endtask

   // terms=63 clamps to 32; with x=0 the result is the last coefficient.
   task automatic test_clamp();
      logic [DW-1:0] y; logic ovf; int lat;
      for (int i = 0; i < 32; i++) mem[i] = i << 16;
      run_eval(32'h0000_0000, 6'd63, -1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== 32'h001F_0000) $display("FAIL clamp_y got %h want 001f0000", y); else pass_cnt++;
      total_cnt++; if (lat !== 34) $display("FAIL clamp_latency got %0d want 34", lat); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 32) $display("FAIL clamp_rdcnt got %0d want 32", rd_cnt); else pass_cnt++;
      finish_eval();
   endtask

   task automatic test_ignore_busy();
      logic [DW-1:0] y; logic ovf; int lat;
      load_basic();
      run_eval(32'h0002_0000, 6'd3, -1, 1'b1, y, ovf, lat);
      total_cnt++; if (y !== 32'h0003_0000) $display("FAIL busy_y got %h want 00030000", y); else pass_cnt++;
      total_cnt++; if (lat !== 5) $display("FAIL busy_latency got %0d want 5", lat); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 3) $display("FAIL busy_rdcnt got %0d want 3", rd_cnt); else pass_cnt++;
      finish_eval();
   endtask

   task automatic test_reset_mid_run();
      logic [DW-1:0] y; logic ovf; int lat;
      load_basic();
      redo_cnt  = 0;
      x_i       = 32'h0002_0000;
      terms_i   = 6'd3;
      x_valid_i = 1'b1;
      @(posedge clk); #1;
      x_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      total_cnt++; if (y_o !== '0) $display("FAIL midrst_y got %h want 0", y_o); else pass_cnt++;
      total_cnt++; if (y_valid_o !== 1'b0) $display("FAIL midrst_yvalid got %b want 0", y_valid_o); else pass_cnt++;
      total_cnt++; if (coeff_rd_en_o !== 1'b0) $display("FAIL midrst_rden got %b want 0", coeff_rd_en_o); else pass_cnt++;
      total_cnt++; if (coeff_redo_o !== 1'b0) $display("FAIL midrst_redo got %b want 0", coeff_redo_o); else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      total_cnt++; if (redo_cnt !== 0) $display("FAIL midrst_redocnt got %0d want 0", redo_cnt); else pass_cnt++;
      @(posedge clk); #1;
      run_eval(32'h0002_0000, 6'd3, -1, 1'b0, y, ovf, lat);
      total_cnt++; if (y !== 32'h0003_0000) $display("FAIL midrst_next_y got %h want 00030000", y); else pass_cnt++;
      total_cnt++; if (lat !== 5) $display("FAIL midrst_next_latency got %0d want 5", lat); else pass_cnt++;
      finish_eval();
   endtask

   initial begin
      x_i           = '0;
      x_valid_i     = 1'b0;
      terms_i       = '0;
      coeff_empty_i = 1'b0;
      y_ready_i     = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      test_reset();
      test_basic();
      test_zero_terms();
      test_empty_stall();
      test_hold_ready();
      test_overflow();
      test_floor();
      test_clamp();
      test_ignore_busy();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
